// File: rtl/lab_datapath_if.sv
// Control/data bundle between fsm_controller and lab_datapath.
// The controller side uses the master modport; the datapath uses the slave modport.
interface lab_datapath_if #(
    parameter int unsigned WIDTH = 16
);
    logic [2:0]       readnum;
    logic [2:0]       writenum;
    logic             write;
    logic             loada;
    logic             loadb;
    logic             loadc;
    logic             loads;
    logic             asel;
    logic             bsel;
    logic [1:0]       vsel;
    logic [1:0]       shift;
    logic [1:0]       ALUop;
    logic [WIDTH-1:0] sximm8;
    logic [WIDTH-1:0] sximm5;
    logic [WIDTH-1:0] mdata;
    logic [7:0]       pc;
    logic [WIDTH-1:0] datapath_out;
    logic [2:0]       Z_out;

    modport master (
        output readnum, writenum, write, loada, loadb, loadc, loads, asel, bsel,
        output vsel, shift, ALUop, sximm8, sximm5, mdata, pc,
        input  datapath_out, Z_out
    );

    modport slave (
        input  readnum, writenum, write, loada, loadb, loadc, loads, asel, bsel,
        input  vsel, shift, ALUop, sximm8, sximm5, mdata, pc,
        output datapath_out, Z_out
    );
endinterface

// File: rtl/lab_datapath.sv
// Register file, A/B operands, shifter, 4-op ALU, C result and {V,N,Z} status.
// Optional macro LAB_DATAPATH_BYPASS_EN forwards same-edge write data to the read port.
module lab_datapath #(
    parameter int unsigned WIDTH = 16
) (
    input  logic           clk,
    input  logic           reset,
    lab_datapath_if.slave  bus
);
    localparam int unsigned Msb = WIDTH - 1;

    logic [WIDTH-1:0] r_rf [8];
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_c;
    logic [2:0]       r_status;

    logic [WIDTH-1:0] w_wdata;
    logic [WIDTH-1:0] w_rdata;
    logic [WIDTH-1:0] w_shift;
    logic [WIDTH-1:0] w_ain;
    logic [WIDTH-1:0] w_bin;
    logic [WIDTH-1:0] w_alu;
    logic             w_v;
    logic             w_bypass;
    logic [2:0]       w_flags;

    always_comb begin
        w_wdata = r_c;
        unique case (bus.vsel)
            2'b00: w_wdata = r_c;
            2'b01: w_wdata = {{(WIDTH-8){1'b0}}, bus.pc};
            2'b10: w_wdata = bus.sximm8;
            2'b11: w_wdata = bus.mdata;
            default: w_wdata = r_c;
        endcase
    end

`ifdef LAB_DATAPATH_BYPASS_EN
    assign w_bypass = bus.write && (bus.writenum == bus.readnum) && (bus.loada || bus.loadb);
`else
    assign w_bypass = 1'b0;
`endif

    assign w_rdata = w_bypass ? w_wdata : r_rf[bus.readnum];

    always_comb begin
        w_shift = r_b;
        unique case (bus.shift)
            2'b00: w_shift = r_b;
            2'b01: w_shift = {r_b[Msb-1:0], 1'b0};
            2'b10: w_shift = {1'b0, r_b[Msb:1]};
            2'b11: w_shift = {r_b[Msb], r_b[Msb:1]};
            default: w_shift = r_b;
        endcase
    end

    assign w_ain = bus.asel ? '0 : r_a;
    assign w_bin = bus.bsel ? bus.sximm5 : w_shift;

    // Overflow: operands' effective signs agree but the result sign differs.
    always_comb begin
        w_alu = '0;
        w_v   = 1'b0;
        unique case (bus.ALUop)
            2'b00: begin
                w_alu = w_ain + w_bin;
                w_v   = (w_ain[Msb] == w_bin[Msb]) && (w_alu[Msb] != w_ain[Msb]);
            end
            2'b01: begin
                w_alu = w_ain - w_bin;
                w_v   = (w_ain[Msb] != w_bin[Msb]) && (w_alu[Msb] != w_ain[Msb]);
            end
            2'b10: w_alu = w_ain & w_bin;
            2'b11: w_alu = ~w_bin;
            default: w_alu = '0;
        endcase
    end

    assign w_flags = {w_v, w_alu[Msb], (w_alu == '0)};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 8; i++) begin
                r_rf[i] <= '0;
            end
            r_a      <= '0;
            r_b      <= '0;
            r_c      <= '0;
            r_status <= '0;
        end else begin
            if (bus.write) r_rf[bus.writenum] <= w_wdata;
            if (bus.loada) r_a <= w_rdata;
            if (bus.loadb) r_b <= w_rdata;
            if (bus.loadc) r_c <= w_alu;
            if (bus.loads) r_status <= w_flags;
        end
    end

    assign bus.datapath_out = r_c;
    assign bus.Z_out        = r_status;
endmodule
